// File: rtl/mem16x8_arb_pkg.sv
// Shared types and constants for the 16x8 memory arbiter.
package mem16x8_arb_pkg;

  // Default memory geometry
  localparam int unsigned DEFAULT_ADDR_W = 4;
  localparam int unsigned DEFAULT_DATA_W = 8;

  // Owner IDs for the two requesters
  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mem16x8_arbiter_rr_pick2.sv
// Combinational 2-way picker.
// Build option: MEMARB_FIXED_PRIO_EN makes requester 0 always win simultaneous
// requests; otherwise PRIO selects the winner when both request.
module rr_pick2
  import mem16x8_arb_pkg::*;
(
  input  logic REQ0,
  input  logic REQ1,
  input  logic PRIO,
  output logic VALID,
  output logic OWNER
);

`ifdef MEMARB_FIXED_PRIO_EN
  // PRIO has no effect in the fixed-priority build
  logic unused_prio;
  assign unused_prio = PRIO;

  // Requester 0 wins whenever it asks
  always_comb begin
    VALID = REQ0 | REQ1;
    OWNER = REQ0_ID;
    if (!REQ0 && REQ1) begin
      OWNER = REQ1_ID;
    end
  end
`else
  // Round-robin: PRIO breaks ties, a lone requester always wins
  always_comb begin
    VALID = REQ0 | REQ1;
    OWNER = REQ0_ID;
    if (REQ0 && REQ1) begin
      OWNER = PRIO;
    end else if (REQ1) begin
      OWNER = REQ1_ID;
    end
  end
`endif

endmodule

// File: rtl/mem16x8_arbiter.sv
// Two-requester arbiter/sequencer for an external 16x8 memory with
// synchronous write and registered read. One command in flight at a time.
// Build option: MEMARB_FIXED_PRIO_EN (see rr_pick2) selects fixed priority.
module mem16x8_arbiter
  import mem16x8_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              WR0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic              REQ1,
  input  logic              WR1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT
);

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rvalid_q, rvalid_d;

  logic                pick_valid;
  logic                pick_owner;

  rr_pick2 u_pick (
    .REQ0  (REQ0),
    .REQ1  (REQ1),
    .PRIO  (prio_q),
    .VALID (pick_valid),
    .OWNER (pick_owner)
  );

  // Next-state: arbitration in IDLE, pointer update on issue, read capture in RDWAIT
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_owner;
          if (pick_owner == REQ1_ID) begin
            cmd_wr_d    = WR1;
            cmd_addr_d  = ADDR1;
            cmd_wdata_d = WDATA1;
          end else begin
            cmd_wr_d    = WR0;
            cmd_addr_d  = ADDR0;
            cmd_wdata_d = WDATA0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        prio_d  = ~owner_q;
        state_d = cmd_wr_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // Memory output is valid one cycle after the read was issued
        rdata_d           = MEM_DOUT;
        rvalid_d[owner_q] = 1'b1;
        state_d           = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Outputs: grant and write-enable only in ISSUE; write also gated by reset so a
  // reset during ISSUE can never corrupt memory
  always_comb begin
    GNT0     = (state_q == ISSUE) && (owner_q == REQ0_ID);
    GNT1     = (state_q == ISSUE) && (owner_q == REQ1_ID);
    MEM_WR   = (state_q == ISSUE) && cmd_wr_q && RST_N;
    MEM_ADDR = cmd_addr_q;
    MEM_DIN  = cmd_wdata_q;
    RDATA    = rdata_q;
    RVALID0  = rvalid_q[0];
    RVALID1  = rvalid_q[1];
  end

endmodule

// File: tb/tb_mem16x8_arbiter.sv
// Scoreboard bench for mem16x8_arbiter with a behavioural 16x8 memory.
module tb_mem16x8_arbiter;

  localparam bit EvGnt = 1'b0;
  localparam bit EvRv  = 1'b1;

  typedef struct {
    bit         kind;
    int         id;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       req   [2];
  logic       wr    [2];
  logic [3:0] addr  [2];
  logic [7:0] wdata [2];
  logic       GNT0, GNT1, RVALID0, RVALID1, MEM_WR;
  logic [7:0] RDATA, MEM_DIN, mem_dout;
  logic [3:0] MEM_ADDR;

  logic [7:0] mem [16];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  ev_t        exp_q [$];

  mem16x8_arbiter dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ0     (req[0]),
    .WR0      (wr[0]),
    .ADDR0    (addr[0]),
    .WDATA0   (wdata[0]),
    .REQ1     (req[1]),
    .WR1      (wr[1]),
    .ADDR1    (addr[1]),
    .WDATA1   (wdata[1]),
    .GNT0     (GNT0),
    .GNT1     (GNT1),
    .RVALID0  (RVALID0),
    .RVALID1  (RVALID1),
    .RDATA    (RDATA),
    .MEM_WR   (MEM_WR),
    .MEM_ADDR (MEM_ADDR),
    .MEM_DIN  (MEM_DIN),
    .MEM_DOUT (mem_dout)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory: synchronous write, registered read
  always @(posedge CLK) begin
    if (MEM_WR) mem[MEM_ADDR] <= MEM_DIN;
    mem_dout <= mem[MEM_ADDR];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input bit kind, input int id, input logic w, input logic [3:0] a,
                          input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d id=%0d at cycle %0d, expected none",
               kind, id, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", int'(kind), int'(e.kind));
    chk("ev_id", id, e.id);
    chk("ev_cycle", cyc, e.cyc);
    if (kind == EvGnt) begin
      chk("gnt_mem_wr", int'(w), int'(e.wr));
      chk("gnt_mem_addr", int'(a), int'(e.addr));
      chk("gnt_mem_din", int'(d), int'(e.data));
    end else begin
      chk("rdata", int'(d), int'(e.data));
    end
  endtask

  // Monitor: sample mid-cycle, pop the scoreboard on every grant or read-valid
  always @(negedge CLK) begin
    chk("gnt_exclusive", int'(GNT0 & GNT1), 0);
    chk("rvalid_exclusive", int'(RVALID0 & RVALID1), 0);
    chk("memwr_only_in_grant", int'(MEM_WR & ~(GNT0 | GNT1)), 0);
    if (GNT0 || GNT1) check_ev(EvGnt, GNT1 ? 1 : 0, MEM_WR, MEM_ADDR, MEM_DIN);
    if (RVALID0 || RVALID1) check_ev(EvRv, RVALID1 ? 1 : 0, 1'b0, 4'd0, RDATA);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One transaction from an idle arbiter: hold until GNT, drop at the edge ending it
  task automatic do_req(input int id, input logic w, input logic [3:0] a, input logic [7:0] wd,
                        input logic [7:0] rexp);
    int c0;
    bit seen;
    c0 = cyc;
    exp_q.push_back('{kind: EvGnt, id: id, wr: w, addr: a, data: wd, cyc: c0 + 1});
    if (!w) exp_q.push_back('{kind: EvRv, id: id, wr: 1'b0, addr: 4'd0, data: rexp, cyc: c0 + 3});
    req[id] = 1'b1; wr[id] = w; addr[id] = a; wdata[id] = wd;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = (id == 1) ? GNT1 : GNT0;
    end
    chk("gnt_wait", int'(seen), 1);
    step();
    req[id] = 1'b0;
    if (!w) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_gnt0"}, int'(GNT0), 0);
    chk({tag, "_gnt1"}, int'(GNT1), 0);
    chk({tag, "_rvalid0"}, int'(RVALID0), 0);
    chk({tag, "_rvalid1"}, int'(RVALID1), 0);
    chk({tag, "_mem_wr"}, int'(MEM_WR), 0);
    chk({tag, "_rdata"}, int'(RDATA), 0);
    chk({tag, "_mem_addr"}, int'(MEM_ADDR), 0);
    chk({tag, "_mem_din"}, int'(MEM_DIN), 0);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h5A; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[9] = 8'h77;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 4'd0; wdata[i] = 8'd0;
    end
    RST_N = 1'b0;
    repeat (3) step();
    check_zero_outputs("reset");
    RST_N = 1'b1;
    step();

    // Reset during RDWAIT: read is dropped, everything back to zero
    c0 = cyc;
    exp_q.push_back('{kind: EvGnt, id: 0, wr: 1'b0, addr: 4'd3, data: 8'h00, cyc: c0 + 1});
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 4'd3; wdata[0] = 8'h00;
    step();
    step();
    req[0] = 1'b0;
    RST_N = 1'b0;
    step();
    check_zero_outputs("midrd_reset");
    step();
    RST_N = 1'b1;
    do_req(1, 1'b0, 4'd2, 8'h00, 8'h22);

    // Both requesters held on reads of addr 1 / addr 2
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_FIXED_PRIO_EN
      exp_q.push_back('{kind: EvGnt, id: 0, wr: 1'b0, addr: 4'd1, data: 8'h00, cyc: c0 + 1 + 3 * k});
      exp_q.push_back('{kind: EvRv, id: 0, wr: 1'b0, addr: 4'd0, data: 8'h11, cyc: c0 + 3 + 3 * k});
`else
      exp_q.push_back('{kind: EvGnt, id: k % 2, wr: 1'b0, addr: (k % 2 == 0) ? 4'd1 : 4'd2,
                        data: 8'h00, cyc: c0 + 1 + 3 * k});
      exp_q.push_back('{kind: EvRv, id: k % 2, wr: 1'b0, addr: 4'd0,
                        data: (k % 2 == 0) ? 8'h11 : 8'h22, cyc: c0 + 3 + 3 * k});
`endif
    end
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 4'd1; wdata[0] = 8'h00;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 4'd2; wdata[1] = 8'h00;
    repeat (11) step();
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (2) step();

    // Single write then read-back
    do_req(0, 1'b1, 4'd5, 8'hA5, 8'h00);
    do_req(0, 1'b0, 4'd5, 8'h00, 8'hA5);

    // Address extremes from alternating requesters; writes leave RDATA alone
    do_req(1, 1'b1, 4'd15, 8'hFF, 8'h00);
    do_req(0, 1'b1, 4'd0, 8'h00, 8'h00);
    chk("rdata_held_over_writes", int'(RDATA), 8'hA5);
    do_req(1, 1'b0, 4'd15, 8'h00, 8'hFF);
    do_req(0, 1'b0, 4'd0, 8'h00, 8'h00);

    // REQ1 pulses only while REQ0 is in ISSUE: must be ignored
    c0 = cyc;
    exp_q.push_back('{kind: EvGnt, id: 0, wr: 1'b1, addr: 4'd7, data: 8'h3C, cyc: c0 + 1});
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 4'd7; wdata[0] = 8'h3C;
    step();
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 4'd9; wdata[1] = 8'h99;
    step();
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (2) step();
    do_req(1, 1'b0, 4'd9, 8'h00, 8'h77);
    do_req(0, 1'b0, 4'd7, 8'h00, 8'h3C);

    repeat (4) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
